// File: rtl/delay_tap_reader_if.sv
// delay_tap_reader_if: sample stream, delay control and status bundle for delay_tap_reader.
//   master : drives in_valid/in_data/delay_sel/load_delay, observes outputs
//   slave  : the delay_tap_reader itself
//   in_valid   - accept in_data on this edge
//   in_data    - sample to write
//   delay_sel  - requested delay in samples (0 is treated as 1)
//   load_delay - latch delay_sel on this edge
//   out_valid  - one-cycle strobe, out_data is a valid delayed sample
//   out_data   - delayed sample, registered
//   primed     - buffer holds at least D samples since last reset/delay load
//   cur_delay  - active delay D
interface delay_tap_reader_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 5
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    delay_sel;
    logic             load_delay;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             primed;
    logic [AW-1:0]    cur_delay;

    modport master (
        output in_valid, in_data, delay_sel, load_delay,
        input  out_valid, out_data, primed, cur_delay
    );

    modport slave (
        input  in_valid, in_data, delay_sel, load_delay,
        output out_valid, out_data, primed, cur_delay
    );
endinterface

// File: rtl/delay_tap_reader.sv
// delay_tap_reader: programmable-delay read side of the sample delay path.
// Accepted samples go into a circular buffer; on each accept the sample
// accepted D samples earlier is read out. out_valid strobes only once the
// buffer holds at least D samples since the last reset or delay load.
//   clock - rising-edge clock
//   reset - asynchronous, active-high; clears all state except buffer RAM
//   bus   - delay_tap_reader_if slave modport (stream, delay control, status)
module delay_tap_reader #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned AW          = 5,
    parameter int unsigned RESET_DELAY = 30
) (
    input  logic                 clock,
    input  logic                 reset,
    delay_tap_reader_if.slave    bus
);

    localparam logic [AW-1:0] FILL_MAX  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] DELAY_RST = AW'(RESET_DELAY);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    fill;
    logic [AW-1:0]    delay_q;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    delay_new;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;

    // Tap address; never equals wp because delay_q is at least 1.
    assign rd_addr   = wp - delay_q;

    // A requested delay of zero is clamped to one.
    assign delay_new = (bus.delay_sel == '0) ? AW'(1) : bus.delay_sel;

    // Buffer RAM, not reset. The tap read below samples pre-write contents.
    always_ff @(posedge clock) begin
        if (bus.in_valid) begin
            mem[wp] <= bus.in_data;
        end
    end

    // Pointer, fill level, active delay and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp          <= '0;
            fill        <= '0;
            delay_q     <= DELAY_RST;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
                wp         <= wp + AW'(1);
                out_data_q <= mem[rd_addr];
            end
            if (bus.load_delay) begin
                // Re-priming: the sample accepted on this edge counts as the first.
                delay_q <= delay_new;
                fill    <= bus.in_valid ? AW'(1) : '0;
            end else if (bus.in_valid) begin
                out_valid_q <= (fill >= delay_q);
                if (fill != FILL_MAX) begin
                    fill <= fill + AW'(1);
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.cur_delay = delay_q;
    assign bus.primed    = (fill >= delay_q);

endmodule

// File: tb/tb_delay_tap_reader.sv
// tb_delay_tap_reader: scoreboard bench for delay_tap_reader. The stimulus
// side keeps the full history of accepted samples and predicts each strobe
// as "sample accepted D accepts ago"; a monitor pops and compares on every
// out_valid strobe.
module tb_delay_tap_reader;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned RD    = 30;

    typedef logic [WIDTH-1:0] data_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    delay_tap_reader_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    delay_tap_reader #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .RESET_DELAY(RD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int    errors = 0;
    int    checks = 0;

    data_t exp_q[$];
    data_t hist[$];
    int    m_d = RD;
    int    m_cnt = 0;
    bit    last_acc_valid = 1'b0;
    data_t last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding prediction.
    always @(negedge clock) begin
        if (!reset && bus.out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected out_valid, data %0h at %0t", bus.out_data, $time);
            end else begin
                data_t e;
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    errors++;
                    $display("FAIL strobe_data: got %0h expected %0h at %0t", bus.out_data, e, $time);
                end
            end
        end
    end

    // One clock of stimulus; status is checked against the model first.
    task automatic step(input bit v, input data_t d, input bit ld, input logic [AW-1:0] sel);
        int  k;
        bit  pv;
        @(negedge clock);
        check("primed", 32'(bus.primed), 32'(m_cnt >= m_d));
        check("cur_delay", 32'(bus.cur_delay), 32'(m_d));
        if (last_acc_valid) check("out_data_hold", 32'(bus.out_data), 32'(last_data));
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.load_delay = ld;
        bus.delay_sel  = sel;
        if (v) begin
            k  = hist.size();
            pv = !ld && (m_cnt >= m_d);
            if (pv) begin
                last_data = hist[k - m_d];
                exp_q.push_back(last_data);
            end
            last_acc_valid = pv;
            hist.push_back(d);
        end
        if (ld) begin
            m_d   = (sel == '0) ? 1 : int'(sel);
            m_cnt = v ? 1 : 0;
        end else if (v) begin
            m_cnt++;
        end
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic async_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_primed", 32'(bus.primed), 32'd0);
        check("rst_cur_delay", 32'(bus.cur_delay), 32'(RD));
        check("rst_queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        hist.delete();
        m_d            = RD;
        m_cnt          = 0;
        last_acc_valid = 1'b0;
        last_data      = '0;
        bus.in_valid   = 1'b0;
        bus.load_delay = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.load_delay = 1'b0;
        bus.delay_sel  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("init_out_valid", 32'(bus.out_valid), 32'd0);
        check("init_out_data", 32'(bus.out_data), 32'd0);
        check("init_primed", 32'(bus.primed), 32'd0);
        check("init_cur_delay", 32'(bus.cur_delay), 32'(RD));

        // Default delay: first strobe on sample 30 carrying sample 0.
        for (int i = 0; i < 40; i++) step(1'b1, data_t'(i), 1'b0, '0);

        // Short delay of 3.
        step(1'b0, '0, 1'b1, AW'(3));
        for (int i = 0; i < 8; i++) step(1'b1, data_t'(8'h10 + i), 1'b0, '0);

        // Zero clamps to 1; gapped stream, out_data holds while idle.
        step(1'b0, '0, 1'b1, AW'(0));
        for (int i = 0; i < 8; i++) begin
            step(1'b1, data_t'(8'hA0 + i), 1'b0, '0);
            idle();
        end

        // Maximum delay across several pointer wraps.
        step(1'b0, '0, 1'b1, AW'(31));
        for (int i = 0; i < 100; i++) step(1'b1, data_t'(i), 1'b0, '0);

        // Delay change mid-stream with a simultaneous accept.
        step(1'b0, '0, 1'b1, AW'(5));
        for (int i = 0; i < 10; i++) step(1'b1, data_t'(8'h40 + i), 1'b0, '0);
        step(1'b1, 8'h4A, 1'b1, AW'(2));
        for (int i = 0; i < 6; i++) step(1'b1, data_t'(8'h4B + i), 1'b0, '0);

        // load_delay held high: never primes, never strobes.
        for (int i = 0; i < 4; i++) step(1'b1, data_t'(8'h60 + i), 1'b1, AW'(1));

        // Asynchronous reset while primed at D=4.
        step(1'b0, '0, 1'b1, AW'(4));
        for (int i = 0; i < 8; i++) step(1'b1, data_t'(8'h70 + i), 1'b0, '0);
        async_reset();
        for (int i = 0; i < 35; i++) step(1'b1, data_t'(8'h80 + i), 1'b0, '0);

        // Randomized traffic with occasional delay loads and resets.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 3) != 0, data_t'($urandom),
                     $urandom_range(0, 39) == 0, AW'($urandom));
            end
        end

        idle();
        idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delay_tap_reader.md
# delay_tap_reader

Programmable-delay read side for the sample delay path. Accepted input samples are written into a circular buffer, and the sample from a selectable number of accepted samples earlier is read back out. It replaces the fixed-length shift-register chain wherever the delay must change at run time. It also marks each output with a valid strobe, and only after the buffer has filled enough to honour the selected delay.

## Interface

Parameters:
- WIDTH, 8, sample width in bits
- DEPTH, 32, buffer entries; power of two, ≥ 4
- AW, 5, log2(DEPTH); pointer and delay width
- RESET_DELAY, 30, delay in samples after reset; range 1..DEPTH-1

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state except buffer contents
- in_valid  input  1  accepts in_data on this edge
- in_data  input  WIDTH  sample to write
- delay_sel  input  AW  requested delay in samples; 0 is treated as 1
- load_delay  input  1  latches delay_sel on this edge
- out_valid  output  1  one-cycle strobe; out_data is a valid delayed sample
- out_data  output  WIDTH  delayed sample, registered
- primed  output  1  buffer holds at least D samples since the last reset or delay load
- cur_delay  output  AW  active delay D

## Operation

- Reset state: wp=0, fill=0, D=RESET_DELAY, out_data=0, out_valid=0, primed=0, cur_delay=RESET_DELAY. Buffer RAM is not reset.
- Accept: at an edge with in_valid=1:
  - mem[wp] <= in_data
  - wp <= wp+1 (mod DEPTH, natural wrap)
  - fill <= min(fill+1, DEPTH-1)
- Read: at the same accepting edge, out_data <= mem[(wp − D) mod DEPTH], read from pre-write contents. The RAM must be read-before-write, or the read must bypass the write; the read address never equals wp because D ≥ 1.
- out_valid <= in_valid AND (fill ≥ D), evaluated on pre-edge fill and D.
- Hold: with in_valid=0, out_valid <= 0; out_data, wp and fill hold.
- Delay load: at an edge with load_delay=1:
  - D <= (delay_sel==0 ? 1 : delay_sel)
  - fill <= 0, or fill <= 1 if in_valid is also 1
  - out_valid <= 0 on that edge, regardless of in_valid
  - The sample accepted on that edge is still written. wp is unaffected and the RAM is not cleared.
- primed = (fill ≥ D), combinational from registers.
- Meaning of the output: after priming, the out_valid strobe for accepted sample k carries sample k−D, where accepted samples are numbered from 0.
- delay_sel values ≥ DEPTH cannot occur (AW bits). D=DEPTH-1 is the maximum and uses the whole ring.

## Timing

- Latency: out_data is updated on the accepting edge. It is visible one cycle after in_valid is sampled and holds until the next accept.
- Throughput: one sample per clock; in_valid may be held high indefinitely.
- Priming: after reset or a delay load, the first D accepts produce out_valid=0. The (D+1)th accept produces the first out_valid=1.
- fill saturates at DEPTH-1 and never wraps. wp wraps from DEPTH-1 to 0 with no gap in output.
- Asynchronous reset mid-stream: outputs go to their reset values immediately, not at the next edge. The first accept after deassertion writes to address 0.
- load_delay held high for several cycles: each edge re-latches and clears fill, so out_valid stays 0 throughout.

## Test plan

- Reset default: reset, then stream in_data=0,1,2,… with in_valid=1 continuously -> out_valid first high on the edge accepting sample 30, with out_data=0; thereafter out_data = sample−30 every cycle; cur_delay=30.
- Short delay: load_delay=1 with delay_sel=3, then stream 0x10,0x11,0x12,… -> first three accepts give out_valid=0; the 4th accept gives out_valid=1, out_data=0x10; primed rises after the 3rd accept.
- Zero clamp and gaps: delay_sel=0 loaded, then in_valid toggling 1,0,1,0 with data 0xA0,0xA1,… -> cur_delay=1; out_valid pulses only on accepting edges after the first, carrying 0xA0, 0xA1, …; out_data holds during idle cycles.
- Wrap and maximum: delay_sel=31, stream 100 samples of an incrementing byte -> out_data = sample−31 across several wp wraps; no missing or duplicated value.
- Delay change mid-stream: running primed at D=5, load delay_sel=2 with in_valid=1 -> out_valid=0 for that edge and the next accept; the next strobe carries sample −2 relative to the accept.
- Asynchronous reset mid-stream: assert reset between edges at D=4 while primed -> out_valid, out_data and primed are 0 before the next edge; after release, out_valid stays 0 for 30 accepts.
